// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked shift-out, ACK.
// Optional: define PS2_HOST_TX_ACK_CHECK_EN to fail transfers whose ACK bit reads high.
module ps2_host_tx #(
    parameter int CLK_HZ      = 50000000,
    parameter int INHIBIT_US  = 100,
    parameter int START_TO_US = 15000,
    parameter int XFER_TO_US  = 2000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int CYC_PER_US = CLK_HZ / 1000000;
    localparam logic [19:0] T_INH   = 20'(CYC_PER_US * INHIBIT_US);
    localparam logic [19:0] T_START = 20'(CYC_PER_US * START_TO_US);
    localparam logic [19:0] T_XFER  = 20'(CYC_PER_US * XFER_TO_US);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, WAIT_FIRST, SHIFT, WAIT_IDLE, DONE, ERR
    } state_t;

    // bit 0 = CLK, bit 1 = DATA
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [FW-1:0] cnt_clk, cnt_dat;
    logic          clk_f, dat_f, fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            cnt_clk <= '0;
            cnt_dat <= '0;
        end else begin
            sync1  <= {ps2_data_in, ps2_clk_in};
            sync2  <= sync1;
            filt_d <= filt;
            if (sync2[0] == filt[0]) begin
                cnt_clk <= '0;
            end else if (cnt_clk == F_LAST) begin
                filt[0] <= sync2[0];
                cnt_clk <= '0;
            end else begin
                cnt_clk <= cnt_clk + FW'(1);
            end
            if (sync2[1] == filt[1]) begin
                cnt_dat <= '0;
            end else if (cnt_dat == F_LAST) begin
                filt[1] <= sync2[1];
                cnt_dat <= '0;
            end else begin
                cnt_dat <= cnt_dat + FW'(1);
            end
        end
    end

    assign clk_f = filt[0];
    assign dat_f = filt[1];
    assign fall  = filt_d[0] & ~filt[0];

    state_t      state;
    logic [19:0] timer;
    logic [3:0]  bitcnt;
    logic [9:0]  frame;

    // frame = {stop, parity, data}; each device fall presents frame[0] and shifts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            bitcnt      <= '0;
            frame       <= '0;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (timer != 20'd0) timer <= timer - 20'd1;
            unique case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        timer      <= T_INH - 20'd1;
                        state      <= INHIBIT;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                INHIBIT: begin
                    if (timer == 20'd0) begin
                        ps2_data_oe <= 1'b1;
                        state       <= RTS;
                    end
                end
                RTS: begin
                    ps2_clk_oe <= 1'b0;
                    timer      <= T_START - 20'd1;
                    state      <= WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (fall) begin
                        ps2_data_oe <= ~frame[0];
                        frame       <= {1'b0, frame[9:1]};
                        bitcnt      <= 4'd1;
                        timer       <= T_XFER - 20'd1;
                        state       <= SHIFT;
                    end else if (timer == 20'd0) begin
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= ERR;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        if (bitcnt == 4'd10) begin
`ifdef PS2_HOST_TX_ACK_CHECK_EN
                            if (dat_f) begin
                                ps2_data_oe <= 1'b0;
                                tx_err      <= 1'b1;
                                state       <= ERR;
                            end else begin
                                state <= WAIT_IDLE;
                            end
`else
                            state <= WAIT_IDLE;
`endif
                        end else begin
                            ps2_data_oe <= ~frame[0];
                            frame       <= {1'b0, frame[9:1]};
                            bitcnt      <= bitcnt + 4'd1;
                        end
                    end else if (timer == 20'd0) begin
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= ERR;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_f && dat_f) begin
                        tx_done <= 1'b1;
                        state   <= DONE;
                    end else if (timer == 20'd0) begin
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= ERR;
                    end
                end
                DONE, ERR: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    tx_ready    <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: open-drain wire model, PS/2 device model, busy/ready model.
module tb_ps2_host_tx;
    localparam int CLK_HZ  = 1000000;
    localparam int INH_US  = 100;
    localparam int STA_US  = 3000;
    localparam int XFER_US = 1000;
    localparam int T_INH   = CLK_HZ / 1000000 * INH_US;
    localparam int T_START = CLK_HZ / 1000000 * STA_US;
    localparam int T_XFER  = CLK_HZ / 1000000 * XFER_US;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ(CLK_HZ), .INHIBIT_US(INH_US), .START_TO_US(STA_US),
        .XFER_TO_US(XFER_US), .FILTER_LEN(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0;
    logic m_busy = 1'b0, m_ready = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Transaction-level model: one request in flight between accept and its result pulse
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
        end else if (m_busy) begin
            if (tx_done || tx_err) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
            end
        end else if (tx_valid && m_ready) begin
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
        end else begin
            m_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (tx_done) done_cnt++;
        if (tx_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        chk("busy", int'(busy), int'(m_busy));
        chk("tx_ready", int'(tx_ready), int'(m_ready));
        chk("pulse_overlap", int'(tx_done & tx_err), 0);
        if (!m_busy)
            chk("idle_quiet", int'({ps2_clk_oe, ps2_data_oe, tx_done, tx_err}), 0);
    end

    // Device: waits for inhibit + RTS, then clocks nfalls bits, sampling DATA before each rise
    task automatic dev_xfer(input int nfalls, input bit ack, input bit glitch, input int hp,
                            output logic [9:0] cap, output int inh, output int rel_cyc);
        int t;
        t = 0;
        cap = '0;
        inh = 0;
        rel_cyc = 0;
        while (!ps2_clk_oe && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!ps2_clk_oe) begin
            fail_now("inhibit_start");
            return;
        end
        while (ps2_clk_oe && inh < 10000) begin
            @(negedge clk);
            inh++;
        end
        if (ps2_clk_oe) begin
            fail_now("inhibit_stuck");
            return;
        end
        rel_cyc = cyc;
        chk("rts_data_low", int'(ps2_data_oe), 1);
        wait_cyc(hp);
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk_low = 1'b1;
            wait_cyc(hp);
            if (k <= 10) cap[k-1] = ps2_data_in;
            dev_clk_low = 1'b0;
            if (k == 10 && ack) dev_data_low = 1'b1;
            if (glitch) begin
                wait_cyc(hp / 2 - 2);
                dev_clk_low = 1'b1;
                wait_cyc(3);
                dev_clk_low = 1'b0;
                wait_cyc(hp - hp / 2 - 1);
            end else begin
                wait_cyc(hp);
            end
            if (k == 11) dev_data_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    // exp_res: 1 = tx_done expected, 2 = tx_err expected
    task automatic run_tx(input logic [7:0] b, input int nfalls, input bit ack, input bit glitch,
                          input int hp, input int exp_res, output logic [9:0] cap);
        int d0, e0, inh, rel, t;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        dev_xfer(nfalls, ack, glitch, hp, cap, inh, rel);
        chk_rng("inhibit_len", inh, T_INH, T_INH + 2);
        t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < T_START + T_XFER) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0 && err_cnt == e0) fail_now("result_pulse");
        wait_cyc(4);
        chk("done_pulses", done_cnt - d0, int'(exp_res == 1));
        chk("err_pulses", err_cnt - e0, int'(exp_res == 2));
        if (nfalls == 0) chk_rng("start_timeout", err_cyc - rel, T_START - 4, T_START + 4);
        if (nfalls >= 10) begin
            chk("byte", int'(cap[7:0]), int'(b));
            chk("parity", int'(cap[8]), int'($countones(b) % 2 == 0));
            chk("stop", int'(cap[9]), 1);
        end
        chk("lines_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("ready_after", int'(tx_ready), 1);
    endtask

    initial begin
        logic [9:0] cap;
        logic [7:0] b;
        int d0, e0, inh, rel, hp;

        wait_cyc(4);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(tx_ready), 0);
        chk("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("rst_pulses", int'({tx_done, tx_err}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", int'(tx_ready), 1);
        wait_cyc(20);

        run_tx(8'hED, 11, 1'b1, 1'b0, 20, 1, cap);
        chk("ed_frame", int'(cap), 'h3ED);

        fork
            run_tx(8'hF4, 11, 1'b1, 1'b0, 20, 1, cap);
            begin
                wait_cyc(200);
                chk("ready_mid", int'(tx_ready), 0);
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                wait_cyc(2);
                tx_valid = 1'b0;
            end
        join
        chk("f4_frame", int'(cap), 'h2F4);
        wait_cyc(100);
        chk("no_second_tx", int'(busy), 0);

        run_tx(8'h12, 0, 1'b0, 1'b0, 20, 2, cap);
        run_tx(8'h3C, 5, 1'b1, 1'b0, 20, 2, cap);
`ifdef PS2_HOST_TX_ACK_CHECK_EN
        run_tx(8'h81, 11, 1'b0, 1'b0, 20, 2, cap);
`else
        run_tx(8'h81, 11, 1'b0, 1'b0, 20, 1, cap);
`endif
        run_tx(8'h5A, 11, 1'b1, 1'b1, 30, 1, cap);
        chk("glitch_frame", int'(cap), 'h35A);

        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        dev_xfer(5, 1'b1, 1'b0, 20, cap, inh, rel);
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_clk_oe", int'(ps2_clk_oe), 0);
        chk("midrst_data_oe", int'(ps2_data_oe), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pulses", int'({tx_done, tx_err}), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(20);
        chk("midrst_no_result", (done_cnt - d0) + (err_cnt - e0), 0);
        run_tx(8'h00, 11, 1'b1, 1'b0, 20, 1, cap);
        chk("zero_frame", int'(cap), 'h300);

        for (int i = 0; i < 6; i++) begin
            b  = 8'($urandom);
            hp = int'($urandom_range(20, 32));
            wait_cyc(int'($urandom_range(1, 40)));
            run_tx(b, 11, 1'b1, 1'b0, hp, 1, cap);
        end

        wait_cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
